mdr_mem_unit: RTL and testbench
===============================

# mdr_mem_unit

Memory-interface stage that produces the MDR operand for the CPU's 32-bit datapath bus. It holds the MAR and MDR registers, runs a single-outstanding read/write handshake with word-addressed memory, and presents the MDR contents to the bus select mux as `BusMuxIn_MDR`. A wait-state counter aborts transfers to non-responding memory.

## Interface
Parameters:
- `ADDR_W`, 9: MAR / memory address width (512 words).
- `TIMEOUT`, 15: maximum cycles in READ/WRITE without `mem_ready` before abort (1..255).

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `BusMuxOut`  in  32  datapath bus value.
- `MARin`  in  1  load MAR from `BusMuxOut[ADDR_W-1:0]`.
- `MDRin`  in  1  load MDR from `BusMuxOut`.
- `rd_start`  in  1  start memory read at MAR into MDR.
- `wr_start`  in  1  start memory write of MDR to MAR.
- `mem_rdata`  in  32  memory read data, valid when `mem_ready`=1 during read.
- `mem_ready`  in  1  memory completion strobe.
- `mem_addr`  out  ADDR_W  current MAR value.
- `mem_wdata`  out  32  current MDR value.
- `mem_rd` / `mem_wr`  out  1  request strobes, held for the whole transfer.
- `BusMuxIn_MDR`  out  32  MDR value to bus mux.
- `busy`  out  1  high in READ or WRITE.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  sticky abort flag.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: `MARin`/`MDRin` load on the edge. `rd_start` -> READ; else `wr_start` -> WRITE (read wins on simultaneous starts; write dropped). Any start clears `timeout` and the wait counter.
- Start with `MDRin` same cycle: start wins, MDR load dropped. Start with `MARin` same cycle: MAR loads, transfer uses the new MAR value (mem_addr always equals MAR).
- READ: `mem_rd`=1. `mem_ready`=1 sampled -> MDR <= `mem_rdata`, -> DONE.
- WRITE: `mem_wr`=1, `mem_wdata`=MDR. `mem_ready`=1 sampled -> DONE; MDR unchanged.
- Wait counter (8-bit) increments each READ/WRITE cycle with `mem_ready`=0; when it reaches TIMEOUT-1 with `mem_ready` still 0: `timeout`<=1, MDR unchanged, -> DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE unconditionally. Starts and `MARin`/`MDRin` ignored in READ, WRITE, DONE.
- `mem_ready` outside READ/WRITE ignored.
- `timeout` holds until next accepted start or reset.

## Timing
- Reset (`clear_n`=0, any time, including mid-transfer): state IDLE, MAR=0, MDR=0, counter=0; all outputs 0 immediately (`mem_rd`, `mem_wr`, `busy`, `done`, `timeout` deassert asynchronously). Aborted transfer is not resumed.
- Strobes are registered state decodes: `rd_start` at edge k -> `mem_rd`/`busy` high from k through the edge where `mem_ready` is sampled.
- Zero-wait memory (`mem_ready`=1 first READ cycle): MDR updated at edge k+1, `done` high cycle k+1..k+2, IDLE at k+2. Minimum start-to-next-start: 3 cycles.
- Timeout: transfer spends exactly TIMEOUT cycles in READ/WRITE, then one DONE cycle with `timeout`=1.
- `BusMuxIn_MDR` changes only on MDR load edges; stable during WRITE.

## Structure
- Shared package `mini_src_pkg`: FSM state enum (`MEM_IDLE`, `MEM_READ`, `MEM_WRITE`, `MEM_DONE`), default `ADDR_W` constant, 32-bit word width constant.
- One sub-module: `mem_wait_timer` (clear, enable, expired output at TIMEOUT-1), instantiated once.

## Test plan
- Reset: drive nonzero MAR/MDR, assert `clear_n`=0 mid-READ -> all outputs 0 same cycle, state IDLE, later `mem_ready` has no effect.
- Zero-wait read: MAR=0x05, `rd_start`, `mem_rdata`=0xDEADBEEF with `mem_ready`=1 first cycle -> `done` at cycle 2, `BusMuxIn_MDR`=0xDEADBEEF, `mem_addr`=0x005.
- Wait-state write: `MDRin` with bus=0x12345678, MAR=0x1FF, `wr_start`, `mem_ready` after 3 low cycles -> `mem_wr` high 4 cycles, `mem_wdata`=0x12345678, one `done` pulse, `timeout`=0.
- Timeout: `rd_start`, `mem_ready` never asserted, TIMEOUT=15 -> `mem_rd` high 15 cycles, `done`+`timeout`=1, MDR unchanged; next `rd_start` clears `timeout`.
- Collisions: `rd_start`+`wr_start`+`MDRin` same cycle -> read only, MDR load dropped; `rd_start` during READ and `MARin` during DONE ignored.
- MAR bypass: `MARin` (bus=0x0000_0ABC) with `rd_start` same cycle -> `mem_addr`=0x0BC during read (ADDR_W=9 truncation).

Source files
------------

// File: rtl/mini_src_pkg.sv
// Shared types and constants for the memory-interface stage of the mini CPU.
package mini_src_pkg;
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_DONE  = 2'd3
    } memState_t;

    localparam int DEF_ADDR_W = 9;
    localparam int WORD_W     = 32;
endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter: counts stalled transfer cycles, flags the last allowed one.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] waitCnt;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            waitCnt <= '0;
        end else if (clr) begin
            waitCnt <= '0;
        end else if (en) begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    assign expired = (waitCnt == LAST);
endmodule

// File: rtl/mdr_mem_unit.sv
// MAR/MDR holding stage with a single-outstanding memory handshake and
// wait-state abort; MDR feeds the datapath bus mux.
module mdr_mem_unit
    import mini_src_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       BusMuxIn_MDR,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    memState_t         state;
    logic [ADDR_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic              timerClr;
    logic              timerEn;
    logic              expired;
    logic              inXfer;

    assign inXfer   = (state == MEM_READ) || (state == MEM_WRITE);
    assign timerClr = (state == MEM_IDLE) && (rd_start || wr_start);
    assign timerEn  = inXfer && !mem_ready;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
        .clock   (clock),
        .clear_n (clear_n),
        .clr     (timerClr),
        .en      (timerEn),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= MEM_IDLE;
            mar     <= '0;
            mdr     <= '0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    // MAR still loads alongside a start so the transfer sees the new address
                    if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
                    if (rd_start) begin
                        state   <= MEM_READ;
                        mem_rd  <= 1'b1;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (wr_start) begin
                        state   <= MEM_WRITE;
                        mem_wr  <= 1'b1;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (MDRin) begin
                        mdr <= BusMuxOut;
                    end
                end
                MEM_READ, MEM_WRITE: begin
                    if (mem_ready || expired) begin
                        if (mem_ready && state == MEM_READ) mdr <= mem_rdata;
                        if (!mem_ready) timeout <= 1'b1;
                        state  <= MEM_DONE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                MEM_DONE: begin
                    state <= MEM_IDLE;
                    done  <= 1'b0;
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    assign mem_addr     = mar;
    assign mem_wdata    = mdr;
    assign BusMuxIn_MDR = mdr;
endmodule

// File: tb/tb_mdr_mem_unit.sv
// Directed bench for mdr_mem_unit: reset, read/write handshakes, timeout, collisions.
module tb_mdr_mem_unit;
    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic        MARin = 1'b0, MDRin = 1'b0, rd_start = 1'b0, wr_start = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, BusMuxIn_MDR;
    logic        mem_rd, mem_wr, busy, done, timeout;

    int checks = 0;
    int failures = 0;

    mdr_mem_unit #(.ADDR_W(9), .TIMEOUT(15)) dut (
        .clock(clock), .clear_n(clear_n), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .rd_start(rd_start), .wr_start(wr_start),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .BusMuxIn_MDR(BusMuxIn_MDR), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({mem_rd, mem_wr, busy, done, timeout} !== 5'b0 || mem_addr !== 9'h0 || BusMuxIn_MDR !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got=%b/%h/%h exp=0", {mem_rd, mem_wr, busy, done, timeout}, mem_addr, BusMuxIn_MDR);
        end
        tick();
        clear_n = 1'b1;
        MARin = 1'b1; BusMuxOut = 32'h0000_0033;
        tick();
        MARin = 1'b0; MDRin = 1'b1; BusMuxOut = 32'hA5A5_A5A5;
        tick();
        MDRin = 1'b0;
        checks++;
        if (mem_addr !== 9'h033 || BusMuxIn_MDR !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL reset_preload got=%h/%h exp=033/a5a5a5a5", mem_addr, BusMuxIn_MDR);
        end
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_read got=%b%b exp=11", mem_rd, busy);
        end
        #2 clear_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, busy, done, timeout} !== 5'b0 || mem_addr !== 9'h0 || BusMuxIn_MDR !== 32'h0) begin
            failures++;
            $display("FAIL reset_async got=%b/%h/%h exp=0", {mem_rd, mem_wr, busy, done, timeout}, mem_addr, BusMuxIn_MDR);
        end
        clear_n = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        mem_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || BusMuxIn_MDR !== 32'h0) begin
            failures++;
            $display("FAIL reset_no_resume got=%b%b/%h exp=00/0", busy, done, BusMuxIn_MDR);
        end
    endtask

    task automatic test_zero_wait_read();
        MARin = 1'b1; BusMuxOut = 32'h0000_0005;
        tick();
        MARin = 1'b0; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || mem_addr !== 9'h005) begin
            failures++;
            $display("FAIL zw_read_start got=%b%b%b/%h exp=110/005", mem_rd, busy, done, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        rd_start = 1'b1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0 || BusMuxIn_MDR !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL zw_read_done got=%b%b%b/%h exp=100/deadbeef", done, busy, mem_rd, BusMuxIn_MDR);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zw_start_in_done got=%b%b exp=00", done, busy);
        end
        tick();
        rd_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got=%b%b exp=11", busy, mem_rd);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || BusMuxIn_MDR !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL b2b_read_done got=%b/%h exp=1/0badf00d", done, BusMuxIn_MDR);
        end
        tick();
    endtask

    task automatic test_wait_write();
        int wrCycles = 0;
        MARin = 1'b1; BusMuxOut = 32'h0000_01FF;
        tick();
        MARin = 1'b0; MDRin = 1'b1; BusMuxOut = 32'h1234_5678;
        tick();
        MDRin = 1'b0; wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        MDRin = 1'b1; BusMuxOut = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            if (mem_wr) wrCycles++;
            if (i == 3) begin
                mem_ready = 1'b1;
                MDRin = 1'b0;
            end
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if (wrCycles !== 4) begin
            failures++;
            $display("FAIL write_wr_cycles got=%0d exp=4", wrCycles);
        end
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL write_done got=%b%b%b exp=100", done, timeout, mem_wr);
        end
        checks++;
        if (mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h1FF) begin
            failures++;
            $display("FAIL write_data got=%h/%h exp=12345678/1ff", mem_wdata, mem_addr);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL write_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_timeout();
        int rdCycles = 0;
        bit sawDone = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int n = 0; n < 40 && !sawDone; n++) begin
            if (mem_rd) rdCycles++;
            if (done) sawDone = 1'b1;
            else tick();
        end
        checks++;
        if (!sawDone) begin
            failures++;
            $display("FAIL timeout_no_done got=0 exp=1 within 40 cycles");
        end
        checks++;
        if (rdCycles !== 15) begin
            failures++;
            $display("FAIL timeout_rd_cycles got=%0d exp=15", rdCycles);
        end
        checks++;
        if (timeout !== 1'b1 || BusMuxIn_MDR !== 32'h1234_5678) begin
            failures++;
            $display("FAIL timeout_flag got=%b/%h exp=1/12345678", timeout, BusMuxIn_MDR);
        end
        mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
        tick();
        tick();
        mem_ready = 1'b0;
        checks++;
        if (timeout !== 1'b1 || done !== 1'b0 || BusMuxIn_MDR !== 32'h1234_5678) begin
            failures++;
            $display("FAIL timeout_sticky got=%b%b/%h exp=10/12345678", timeout, done, BusMuxIn_MDR);
        end
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_clear got=%b%b exp=01", timeout, busy);
        end
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_collisions();
        rd_start = 1'b1; wr_start = 1'b1; MDRin = 1'b1; BusMuxOut = 32'hCAFE_F00D;
        tick();
        wr_start = 1'b0; MDRin = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || BusMuxIn_MDR !== 32'h1111_2222) begin
            failures++;
            $display("FAIL coll_read_wins got=%b%b/%h exp=10/11112222", mem_rd, mem_wr, BusMuxIn_MDR);
        end
        tick();
        rd_start = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL coll_start_in_read got=%b%b exp=10", mem_rd, done);
        end
        mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        mem_ready = 1'b0;
        MARin = 1'b1; BusMuxOut = 32'h0000_0077;
        checks++;
        if (done !== 1'b1 || BusMuxIn_MDR !== 32'h55AA_55AA) begin
            failures++;
            $display("FAIL coll_read_done got=%b/%h exp=1/55aa55aa", done, BusMuxIn_MDR);
        end
        tick();
        MARin = 1'b0;
        checks++;
        if (mem_addr !== 9'h1FF) begin
            failures++;
            $display("FAIL coll_marin_in_done got=%h exp=1ff", mem_addr);
        end
    endtask

    task automatic test_mar_bypass();
        MARin = 1'b1; rd_start = 1'b1; BusMuxOut = 32'h0000_0ABC;
        tick();
        MARin = 1'b0; rd_start = 1'b0;
        checks++;
        if (mem_addr !== 9'h0BC || mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL mar_bypass got=%h/%b exp=0bc/1", mem_addr, mem_rd);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0000_0001;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || BusMuxIn_MDR !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mar_bypass_done got=%b/%h exp=1/00000001", done, BusMuxIn_MDR);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_timeout();
        test_collisions();
        test_mar_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
